// File: rtl/fifo_arbiter.sv
// Burst-limited round-robin arbiter that drains four source FIFOs into one
// downstream FIFO, with stall on downstream almost-full.
module fifo_arbiter #(
  parameter int WIDTH = 10,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       src_empty,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             dst_almost_full,
  output logic [3:0]       pop,
  output logic             push_out,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       grant,
  output logic [1:0]       state,
  output logic             idle_out
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACTIVE = 2'b01;
  localparam logic [1:0] S_STALL  = 2'b10;
  localparam logic [2:0] BURST_LAST = 3'(BURST - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_grant;
  logic [2:0]       r_cnt;
  logic             r_push;
  logic [1:0]       r_src;

  logic             w_all_empty;
  logic             w_pop_ok;
  logic             w_rotate;
  logic [1:0]       w_next_grant;
  logic             w_found;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_data_sel;

  assign w_all_empty = (src_empty == 4'b1111);
  assign w_pop_ok    = (r_state == S_ACTIVE) && enable && !src_empty[r_grant] && !dst_almost_full;
  assign w_rotate    = (w_pop_ok && (r_cnt == BURST_LAST)) || src_empty[r_grant];

  // First non-empty source after the current grant; falls back to the current grant.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_next_grant = r_grant;
    w_found      = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (!w_found && !src_empty[2'(r_grant + 2'(k))]) begin
        w_next_grant = 2'(r_grant + 2'(k));
        w_found      = 1'b1;
      end
    end
  end

  // Leaving for IDLE outranks both the stall and the resume condition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && !w_all_empty && !dst_almost_full) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_all_empty || !enable)  w_state_nxt = S_IDLE;
        else if (dst_almost_full)    w_state_nxt = S_STALL;
      end
      S_STALL: begin
        if (w_all_empty || !enable)  w_state_nxt = S_IDLE;
        else if (!dst_almost_full)   w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= 2'd0;
      r_cnt   <= 3'd0;
      r_push  <= 1'b0;
      r_src   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_pop_ok;
      if (w_pop_ok) r_src <= r_grant;
      if (r_state == S_ACTIVE) begin
        if (w_rotate) begin
          r_grant <= w_next_grant;
          r_cnt   <= 3'd0;
        end else if (w_pop_ok) begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  // Source read data arrives one cycle after the pop, aligned with r_push.
  always_comb begin
    w_data_sel = data_in0;
    case (r_src)
      2'd0:    w_data_sel = data_in0;
      2'd1:    w_data_sel = data_in1;
      2'd2:    w_data_sel = data_in2;
      default: w_data_sel = data_in3;
    endcase
  end

  assign pop      = w_pop_ok ? (4'b0001 << r_grant) : 4'b0000;
  assign push_out = r_push;
  assign data_out = r_push ? w_data_sel : '0;
  assign grant    = r_grant;
  assign state    = r_state;
  assign idle_out = (r_state == S_IDLE) && !r_push;

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter WIDTH, default 10: data word width of every source and of the output.
REQ-002 Parameter BURST, default 4: maximum consecutive pops from one source before the grant rotates; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 enable  input  1  1 = arbitration allowed; 0 = no new pops.
REQ-006 src_empty  input  4  per-source FIFO empty flag; bit n = source n.
REQ-007 data_in0..data_in3  input  WIDTH each  source FIFO read data, valid in the cycle after that source's pop.
REQ-008 dst_almost_full  input  1  downstream FIFO almost-full flag.
REQ-009 pop  output  4  one-hot pop strobe to source FIFOs.
REQ-010 push_out  output  1  push strobe to downstream FIFO.
REQ-011 data_out  output  WIDTH  word pushed downstream, valid while push_out=1.
REQ-012 grant  output  2  index of the currently granted source.
REQ-013 state  output  2  FSM state: IDLE=00, ACTIVE=01, STALL=10.
REQ-014 idle_out  output  1  1 when state=IDLE and push_out=0.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACTIVE and STALL.
REQ-016 IDLE->ACTIVE SHALL occur when enable=1, src_empty!=4'b1111 and dst_almost_full=0.
REQ-017 ACTIVE->STALL SHALL occur when dst_almost_full=1 and src_empty!=4'b1111.
REQ-018 STALL->ACTIVE SHALL occur when dst_almost_full=0.
REQ-019 ACTIVE or STALL->IDLE SHALL occur when src_empty=4'b1111 or enable=0; this takes priority over REQ-017 and REQ-018.
REQ-020 pop[grant] SHALL be 1 only when state=ACTIVE, enable=1, src_empty[grant]=0 and dst_almost_full=0; all other pop bits SHALL be 0.
REQ-021 pop SHALL be a combinational decode of the registered state, grant and the current inputs; at most one bit is high in any cycle.
REQ-022 push_out SHALL be high in cycle t+1 for each pop issued in cycle t (latency 1).
REQ-023 data_out in cycle t+1 SHALL equal data_in of the source popped in cycle t; the source index SHALL be registered with the pop.
REQ-024 A 3-bit burst counter SHALL increment on each pop and clear when the grant changes.
REQ-025 The grant SHALL rotate when the counter reaches BURST-1 with a pop, or when src_empty[grant]=1 in ACTIVE.
REQ-026 Rotation SHALL select the first non-empty source in order grant+1, grant+2, grant+3 (mod 4).
REQ-027 If no other source is non-empty, the grant SHALL stay and the counter SHALL clear.
REQ-028 In STALL and IDLE, grant and the counter SHALL hold.
REQ-029 A pop issued in the last ACTIVE cycle SHALL still produce its push_out in the next cycle, regardless of the new state.
REQ-030 dst_almost_full SHALL block a new pop in the same cycle it is sampled high.

Reset
REQ-031 While reset=0, asynchronously: state=IDLE, grant=0, counter=0, pop=0, push_out=0, data_out=0, idle_out=1.
REQ-032 Reset asserted mid-burst SHALL discard the in-flight push; no push_out SHALL occur after reset releases until a new pop is issued.
REQ-033 After reset releases, the first transition SHALL take effect no earlier than the first rising edge with reset=1.

Verification
REQ-034 Only source 2 non-empty with 3 words, BURST=4 -> pops at source 2 in 3 consecutive cycles; push_out 3 cycles, each one cycle later; data_out matches in order; then IDLE.
REQ-035 All sources hold 8 words, BURST=4 -> grant sequence 0,1,2,3,0 with exactly 4 pops each; no idle cycle between bursts.
REQ-036 dst_almost_full raised mid-burst at source 1 after 2 pops -> pop=0 that cycle, state=STALL, counter=2 held; on release resumes source 1 for 2 more pops then rotates.
REQ-037 Source 3 empties after 1 pop while source 0 non-empty -> grant moves to 0 (wrap) next cycle, counter=0.
REQ-038 reset pulsed low while pop[1]=1 -> all outputs zero immediately; no push_out after release; grant=0.
REQ-039 enable dropped in ACTIVE -> state=IDLE next cycle; pop=0; the pending push_out still fires once.
